// File: rtl/hc595_if.sv
// hc595_if: scan-stage inputs and 74HC595 pin outputs of the serial display driver
//   sel, seg         : one-hot digit select / segment pattern from the scan stage
//   ds, shcp, stcp   : serial data, shift clock, storage (latch) clock to the 595 chain
//   oe_n, frame_done : output enable (active-low), one-clk pulse per completed latch
interface hc595_if;
    logic [7:0] sel;
    logic [7:0] seg;
    logic       ds;
    logic       shcp;
    logic       stcp;
    logic       oe_n;
    logic       frame_done;
    modport master (input sel, seg, output ds, shcp, stcp, oe_n, frame_done);
    modport slave (output sel, seg, input ds, shcp, stcp, oe_n, frame_done);
endinterface

// File: rtl/hc595_drv.sv
// hc595_drv: continuously refreshes two cascaded 74HC595s with {seg, sel}, MSB first
//   clk, rst : system clock, synchronous active-high reset
//   bus      : hc595_if master (sel/seg in; ds, shcp, stcp, oe_n, frame_done out)
//   DIV      : clk cycles per shift-timing tick (2..65535)
module hc595_drv #(
    parameter int DIV = 4
) (
    input  logic     clk,
    input  logic     rst,
    hc595_if.master  bus
);
    typedef enum logic [1:0] {LOAD, SHIFT_L, SHIFT_H, LATCH} state_t;
    state_t      state;
    logic [15:0] div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] sr;
    logic        tick;
    assign tick = div_cnt == 16'(DIV - 1);
    // The top of the shift register is the registered serial data bit.
    assign bus.ds = sr[15];
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt        <= '0;
            state          <= LOAD;
            bit_cnt        <= '0;
            sr             <= '0;
            bus.shcp       <= 1'b0;
            bus.stcp       <= 1'b0;
            bus.oe_n       <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            div_cnt        <= tick ? '0 : div_cnt + 16'd1;
            bus.frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    LOAD: begin
                        sr      <= {bus.seg, bus.sel};
                        bit_cnt <= '0;
                        state   <= SHIFT_L;
                    end
                    SHIFT_L: begin
                        bus.shcp <= 1'b1;
                        state    <= SHIFT_H;
                    end
                    SHIFT_H: begin
                        bus.shcp <= 1'b0;
                        if (bit_cnt == 4'd15) begin
                            bus.stcp <= 1'b1;
                            state    <= LATCH;
                        end else begin
                            sr      <= {sr[14:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                            state   <= SHIFT_L;
                        end
                    end
                    default: begin
                        bus.stcp       <= 1'b0;
                        bus.frame_done <= 1'b1;
                        bus.oe_n       <= 1'b0;
                        state          <= LOAD;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hc595_drv.sv
// tb_hc595_drv: directed self-checking bench for hc595_drv at DIV=4 and DIV=2
module tb_hc595_drv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    hc595_if bus_a ();
    hc595_if bus_b ();
    hc595_drv #(.DIV(4)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    hc595_drv #(.DIV(2)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    always #5 clk = ~clk;

    logic [1:0] m_ds, m_sh, m_st, m_oe, m_fd;
    assign m_ds = {bus_b.ds, bus_a.ds};
    assign m_sh = {bus_b.shcp, bus_a.shcp};
    assign m_st = {bus_b.stcp, bus_a.stcp};
    assign m_oe = {bus_b.oe_n, bus_a.oe_n};
    assign m_fd = {bus_b.frame_done, bus_a.frame_done};

    // Behavioural 2x595 chain plus pin-timing observers, one per DUT.
    logic [15:0] sr_m[2] = '{16'h0, 16'h0};
    logic [15:0] latch_m[2] = '{16'h0, 16'h0};
    int rises[2] = '{0, 0};
    int rises_frame[2] = '{0, 0};
    int stcp_cnt[2] = '{0, 0};
    int overlap[2] = '{0, 0};
    int hi_len[2] = '{0, 0};
    int hi_min[2] = '{1000, 1000};
    int hi_max[2] = '{0, 0};
    int lo_len[2] = '{0, 0};
    int lo_min[2] = '{1000, 1000};
    int st_len[2] = '{0, 0};
    int st_last[2] = '{0, 0};
    int ds_age[2] = '{0, 0};
    int ds_err[2] = '{0, 0};
    int oe_err[2] = '{0, 0};
    int fd_t[2] = '{0, 0};
    int fd_per[2] = '{0, 0};
    int cyc = 0;
    logic shq[2] = '{1'b0, 1'b0};
    logic stq[2] = '{1'b0, 1'b0};
    logic dsq[2] = '{1'b0, 1'b0};
    logic seen_fd[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                sr_m[i]    <= '0;
                rises[i]   <= 0;
                hi_len[i]  <= 0;
                lo_len[i]  <= 0;
                st_len[i]  <= 0;
                shq[i]     <= 1'b0;
                stq[i]     <= 1'b0;
                dsq[i]     <= 1'b0;
                ds_age[i]  <= 0;
                seen_fd[i] <= 1'b0;
            end else begin
                shq[i]    <= m_sh[i];
                stq[i]    <= m_st[i];
                dsq[i]    <= m_ds[i];
                ds_age[i] <= (m_ds[i] !== dsq[i]) ? 1 : ds_age[i] + 1;
                if (m_sh[i]) begin
                    hi_len[i] <= hi_len[i] + 1;
                    lo_len[i] <= 0;
                    if (m_ds[i] !== dsq[i] || (!shq[i] && ds_age[i] < ((i == 0) ? 4 : 2)))
                        ds_err[i] <= ds_err[i] + 1;
                    if (!shq[i]) begin
                        sr_m[i]  <= {sr_m[i][14:0], m_ds[i]};
                        rises[i] <= rises[i] + 1;
                        if (lo_len[i] < lo_min[i]) lo_min[i] <= lo_len[i];
                    end
                end else begin
                    lo_len[i] <= lo_len[i] + 1;
                    hi_len[i] <= 0;
                    if (shq[i]) begin
                        if (hi_len[i] < hi_min[i]) hi_min[i] <= hi_len[i];
                        if (hi_len[i] > hi_max[i]) hi_max[i] <= hi_len[i];
                    end
                end
                if (m_st[i]) begin
                    st_len[i] <= st_len[i] + 1;
                    if (!stq[i]) begin
                        latch_m[i]     <= sr_m[i];
                        rises_frame[i] <= rises[i];
                        rises[i]       <= 0;
                        stcp_cnt[i]    <= stcp_cnt[i] + 1;
                    end
                end else begin
                    st_len[i] <= 0;
                    if (stq[i]) st_last[i] <= st_len[i];
                end
                if (m_sh[i] && m_st[i]) overlap[i] <= overlap[i] + 1;
                if (m_fd[i]) begin
                    seen_fd[i] <= 1'b1;
                    fd_per[i]  <= cyc - fd_t[i];
                    fd_t[i]    <= cyc;
                end
                if (m_oe[i] !== ((seen_fd[i] || m_fd[i]) ? 1'b0 : 1'b1)) oe_err[i] <= oe_err[i] + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of clk edges until DIV=4 frame_done is seen, 0 on timeout.
    task automatic wait_fd(output int k);
        k = 0;
        for (int n = 1; n <= 300; n++) begin
            step();
            if (bus_a.frame_done) begin
                k = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.seg = 8'hFF; bus_a.sel = 8'hFF;
        bus_b.seg = 8'hA5; bus_b.sel = 8'h5A;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if ({bus_a.ds, bus_a.shcp, bus_a.stcp, bus_a.oe_n, bus_a.frame_done} !== 5'b00010) begin
                errors++;
                $display("FAIL reset_a: got %b expected 00010", {bus_a.ds, bus_a.shcp, bus_a.stcp, bus_a.oe_n, bus_a.frame_done});
            end
            checks++;
            if ({bus_b.ds, bus_b.shcp, bus_b.stcp, bus_b.oe_n, bus_b.frame_done} !== 5'b00010) begin
                errors++;
                $display("FAIL reset_b: got %b expected 00010", {bus_b.ds, bus_b.shcp, bus_b.stcp, bus_b.oe_n, bus_b.frame_done});
            end
        end
    endtask

    task automatic test_first_tick();
        bus_a.seg = 8'h40; bus_a.sel = 8'h01;
        bus_b.seg = 8'h40; bus_b.sel = 8'h01;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (bus_a.shcp !== (k >= 8)) begin
                errors++;
                $display("FAIL first_shcp_a edge %0d: got %b expected %b", k, bus_a.shcp, k >= 8);
            end
            checks++;
            if (bus_b.shcp !== (k == 4 || k == 5 || k == 8)) begin
                errors++;
                $display("FAIL first_shcp_b edge %0d: got %b expected %b", k, bus_b.shcp, k == 4 || k == 5 || k == 8);
            end
        end
        checks++;
        if (bus_a.oe_n !== 1'b1) begin errors++; $display("FAIL oe_before_frame: got %b expected 1", bus_a.oe_n); end
    endtask

    task automatic test_data();
        int k;
        wait_fd(k);
        checks++;
        if (k != 128) begin errors++; $display("FAIL first_frame_edge: got %0d expected 128", k); end
        checks++;
        if (bus_a.oe_n !== 1'b0) begin errors++; $display("FAIL oe_after_frame: got %b expected 0", bus_a.oe_n); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (latch_m[i] !== 16'h4001) begin errors++; $display("FAIL data_latch[%0d]: got %h expected 4001", i, latch_m[i]); end
            checks++;
            if (rises_frame[i] != 16) begin errors++; $display("FAIL data_rises[%0d]: got %0d expected 16", i, rises_frame[i]); end
        end
    endtask

    task automatic test_timing();
        int k;
        int dv;
        wait_fd(k);
        checks++;
        if (k != 136) begin errors++; $display("FAIL frame_gap: got %0d expected 136", k); end
        step();
        for (int i = 0; i < 2; i++) begin
            dv = (i == 0) ? 4 : 2;
            checks++;
            if (fd_per[i] != 34 * dv) begin errors++; $display("FAIL fd_period[%0d]: got %0d expected %0d", i, fd_per[i], 34 * dv); end
            checks++;
            if (hi_min[i] != dv || hi_max[i] != dv) begin errors++; $display("FAIL shcp_high[%0d]: got %0d..%0d expected %0d", i, hi_min[i], hi_max[i], dv); end
            checks++;
            if (lo_min[i] != dv) begin errors++; $display("FAIL shcp_low[%0d]: got %0d expected %0d", i, lo_min[i], dv); end
            checks++;
            if (st_last[i] != dv) begin errors++; $display("FAIL stcp_high[%0d]: got %0d expected %0d", i, st_last[i], dv); end
            checks++;
            if (overlap[i] != 0) begin errors++; $display("FAIL overlap[%0d]: got %0d expected 0", i, overlap[i]); end
            checks++;
            if (ds_err[i] != 0) begin errors++; $display("FAIL ds_setup[%0d]: got %0d expected 0", i, ds_err[i]); end
            checks++;
            if (oe_err[i] != 0) begin errors++; $display("FAIL oe_seq[%0d]: got %0d expected 0", i, oe_err[i]); end
        end
    endtask

    task automatic test_mid_change();
        int k;
        bus_a.seg = 8'h79;
        repeat (45) step();
        checks++;
        if (u_a.bit_cnt !== 4'd5) begin errors++; $display("FAIL change_point: got %0d expected 5", u_a.bit_cnt); end
        bus_a.seg = 8'h24;
        wait_fd(k);
        checks++;
        if (k != 90) begin errors++; $display("FAIL change_frame_edge: got %0d expected 90", k); end
        checks++;
        if (latch_m[0] !== 16'h7901) begin errors++; $display("FAIL change_cur: got %h expected 7901", latch_m[0]); end
        wait_fd(k);
        checks++;
        if (k != 136) begin errors++; $display("FAIL change_next_edge: got %0d expected 136", k); end
        checks++;
        if (latch_m[0] !== 16'h2401) begin errors++; $display("FAIL change_next: got %h expected 2401", latch_m[0]); end
    endtask

    task automatic test_reset_mid();
        int k;
        int sc;
        bus_a.seg = 8'hA5; bus_a.sel = 8'h3C;
        repeat (65) step();
        checks++;
        if (u_a.bit_cnt !== 4'd7 || bus_a.shcp !== 1'b1) begin
            errors++;
            $display("FAIL abort_point: got bit %0d shcp %b expected bit 7 shcp 1", u_a.bit_cnt, bus_a.shcp);
        end
        sc = stcp_cnt[0];
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_a.seg = 8'h81; bus_a.sel = 8'h5A;
        checks++;
        if ({bus_a.ds, bus_a.shcp, bus_a.stcp, bus_a.oe_n, bus_a.frame_done} !== 5'b00010) begin
            errors++;
            $display("FAIL abort_outputs: got %b expected 00010", {bus_a.ds, bus_a.shcp, bus_a.stcp, bus_a.oe_n, bus_a.frame_done});
        end
        repeat (3) step();
        checks++;
        if (bus_a.ds !== 1'b0) begin errors++; $display("FAIL restart_pre_load: got %b expected 0", bus_a.ds); end
        step();
        checks++;
        if (bus_a.ds !== 1'b1 || bus_a.oe_n !== 1'b1) begin
            errors++;
            $display("FAIL restart_load: got ds %b oe_n %b expected ds 1 oe_n 1", bus_a.ds, bus_a.oe_n);
        end
        wait_fd(k);
        checks++;
        if (k != 132) begin errors++; $display("FAIL restart_frame_edge: got %0d expected 132", k); end
        checks++;
        if (stcp_cnt[0] != sc + 1) begin errors++; $display("FAIL abort_stcp: got %0d expected %0d", stcp_cnt[0], sc + 1); end
        checks++;
        if (latch_m[0] !== 16'h815A) begin errors++; $display("FAIL restart_latch: got %h expected 815a", latch_m[0]); end
        checks++;
        if (bus_a.oe_n !== 1'b0) begin errors++; $display("FAIL restart_oe: got %b expected 0", bus_a.oe_n); end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_data();
        test_timing();
        test_mid_change();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
